axi_lite_slave_regs: RTL
========================

Name: axi_lite_slave_regs

Overview:
- AXI4-Lite responder: a memory-mapped register file that sits on the slave side of the team's AXI4-Lite interface, answering a single master.
- Provides NUM_REGS word registers. Their contents drive fabric control logic through a flat output bus.
- Write and read paths are fully independent.
- Invalid addresses complete with SLVERR; the bus never hangs.

Parameters:
ADDR_WIDTH, 32, AWADDR/ARADDR width
DATA_WIDTH, 32, data width; 32 or 64 only
NUM_REGS, 16, number of word registers; 2..256

Ports:
ACLK  in  1  clock; all logic on rising edge
ARESETN  in  1  asynchronous active-low reset
AWADDR  in  ADDR_WIDTH  write address
AWVALID  in  1  write address valid
AWREADY  out  1  write address ready
WDATA  in  DATA_WIDTH  write data
WVALID  in  1  write data valid
WREADY  out  1  write data ready
BRESP  out  2  write response
BVALID  out  1  write response valid
BREADY  in  1  write response ready
ARADDR  in  ADDR_WIDTH  read address
ARVALID  in  1  read address valid
ARREADY  out  1  read address ready
RDATA  out  DATA_WIDTH  read data
RRESP  out  2  read response
RVALID  out  1  read data valid
RREADY  in  1  read data ready
reg_out  out  NUM_REGS*DATA_WIDTH  register contents; reg i at [i*DATA_WIDTH +: DATA_WIDTH]
reg_wr_stb  out  NUM_REGS  one-cycle pulse per successfully written register

Behaviour:
Reset and common rules:
- Reset values: all outputs are registered and reset to 0, including AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA, reg_out and reg_wr_stb.
- First cycle after reset release: AWREADY, WREADY and ARREADY go to 1.
- Address decode: ADDR_LSB = log2(DATA_WIDTH/8). Index = ADDR[ADDR_LSB +: clog2(NUM_REGS)].
- Low (sub-word) address bits are ignored.
- Any set address bit above the index field, or index >= NUM_REGS, is out-of-range.
- Response codes: OKAY = 2'b00, SLVERR = 2'b10.

Write FSM (WR_IDLE, WR_RESP):
- WR_IDLE: AWREADY = ~aw_held and WREADY = ~w_held.
  - AW handshake: capture AWADDR, set aw_held, drop AWREADY at the next edge.
  - W handshake: capture WDATA, set w_held, drop WREADY at the next edge.
  - AW and W may arrive in either order or in the same cycle.
- Commit edge: the edge where the second of the pair completes, using the incoming or held values.
  - In range: write the register, set BRESP=OKAY, pulse reg_wr_stb[idx] for exactly one cycle.
  - Out of range: no write, no strobe, BRESP=SLVERR.
  - At the same edge: BVALID=1, clear both held flags, go to WR_RESP.
- WR_RESP: AWREADY=WREADY=0. BVALID and BRESP stay stable until BREADY.
- At the edge with BVALID&&BREADY: BVALID=0, AWREADY=WREADY=1, return to WR_IDLE.
- Peak throughput: one write per 2 cycles when BREADY is held high.

Read FSM (RD_IDLE, RD_DATA):
- RD_IDLE: ARREADY=1. On ARVALID&&ARREADY, at the same edge:
  - RDATA = reg[idx] and RRESP=OKAY, or RDATA=0 and RRESP=SLVERR if out of range.
  - RVALID=1, ARREADY=0, go to RD_DATA.
- RD_DATA: RDATA, RRESP and RVALID stay stable until RREADY, even if the register is written meanwhile.
- At the edge with RVALID&&RREADY: RVALID=0, ARREADY=1.
- Read latency: RVALID is high the cycle after the AR handshake.

Boundary conditions:
- Read and write commit to the same register at the same edge: the read returns the old value.
- VALID held while the corresponding READY is low: no capture, no side effect.
- ARESETN asserted mid-transaction: immediate return to idle, all registers cleared, and any in-flight response is dropped.

Decomposition:
- Package axi_lite_pkg:
  - axi_resp_t enum (OKAY, EXOKAY, SLVERR, DECERR).
  - wr_state_t and rd_state_t enums.
  - Function addr_lsb(DATA_WIDTH).
- Sub-module axi_lite_slave_wr_ctrl: AW/W capture, pairing and B-channel FSM.
  - Outputs a commit pulse with index and data to the top, which owns the register array and the read path.

Test Plan:
- Write 0xDEADBEEF to addr 0x08 with AW and W in the same cycle, BREADY=1 -> BVALID one cycle later, BRESP=00, reg_wr_stb[2] pulses once, reg_out word 2 = 0xDEADBEEF. Then read 0x08 -> RVALID the cycle after the AR handshake, RDATA=0xDEADBEEF, RRESP=00.
- W three cycles before AW (addr 0x04, data 0x12345678) -> WREADY low after the W handshake, no commit until AW arrives; BRESP=00, reg 1 = 0x12345678.
- Write to 0x40 and read 0x40 with NUM_REGS=16 -> BRESP=10 with no register change and no strobe; RRESP=10 with RDATA=0.
- Hold BREADY=0 for 5 cycles after a write -> BVALID and BRESP stable throughout; AWREADY and WREADY stay 0 until the cycle after BREADY=1.
- Read reg 3 (value 0xA5) and write 0x5A to reg 3, committing at the same edge; hold RREADY=0 for 3 cycles -> RDATA=0xA5 throughout, reg 3 = 0x5A afterwards.
- Assert ARESETN low while in WR_RESP and RD_DATA -> all outputs 0 immediately; the READY signals return to 1 in the first cycle after release; all registers read back 0.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared types for the AXI4-Lite register slave.
// Response codes, FSM states, address helper.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_t;

  typedef enum logic {
    WR_IDLE,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_DATA
  } rd_state_t;

  // Byte-offset bits of one data word.
  function automatic int addr_lsb(input int dw);
    return (dw == 64) ? 3 : 2;
  endfunction

endpackage

// File: rtl/axi_lite_slave_wr_ctrl.sv
// AXI4-Lite write side: AW/W capture, pairing, B channel.
// Emits a commit pulse with index/data to the register owner.
module axi_lite_slave_wr_ctrl
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int IDX_W      = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  output logic                  commit,
  output logic [IDX_W-1:0]      commit_idx,
  output logic [DATA_WIDTH-1:0] commit_data
);

  localparam int LSB = addr_lsb(DATA_WIDTH);
  localparam logic [IDX_W:0] NREGS = NUM_REGS[IDX_W:0];

  wr_state_t             state_q, state_d;
  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q, w_held_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  axi_resp_t             bresp_q, bresp_d;

  logic                  aw_hs, w_hs;
  logic                  have_aw, have_w;
  logic                  pair, in_range;
  logic [ADDR_WIDTH-1:0] addr_use;
  logic [IDX_W-1:0]      idx;

  // Pair AW with W (held or incoming) and run the B handshake.
  always_comb begin
    aw_hs    = awvalid & awready_q;
    w_hs     = wvalid & wready_q;
    have_aw  = aw_held_q | aw_hs;
    have_w   = w_held_q | w_hs;
    addr_use = aw_held_q ? addr_q : awaddr;
    idx      = addr_use[LSB +: IDX_W];
    in_range = ((addr_use >> (LSB + IDX_W)) == '0)
             && ({1'b0, idx} < NREGS);
    pair     = (state_q == WR_IDLE) & have_aw & have_w;

    commit      = pair & in_range;
    commit_idx  = idx;
    commit_data = w_held_q ? data_q : wdata;

    state_d   = state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    addr_d    = addr_q;
    data_d    = data_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;

    unique case (state_q)
      WR_IDLE: begin
        if (pair) begin
          state_d   = WR_RESP;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          bvalid_d  = 1'b1;
          bresp_d   = in_range ? OKAY : SLVERR;
        end else begin
          aw_held_d = have_aw;
          w_held_d  = have_w;
          awready_d = ~have_aw;
          wready_d  = ~have_w;
          if (aw_hs) addr_d = awaddr;
          if (w_hs)  data_d = wdata;
        end
      end
      WR_RESP: begin
        if (bready) begin
          state_d   = WR_IDLE;
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
      default: state_d = WR_IDLE;
    endcase
  end

  // Write-side state and registered channel outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= WR_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
    end else begin
      state_q   <= state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;

endmodule

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite register file slave: owns registers and read path.
// Write channel handling lives in axi_lite_slave_wr_ctrl.
module axi_lite_slave_regs
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic                           WVALID,
  output logic                           WREADY,
  output logic [1:0]                     BRESP,
  output logic                           BVALID,
  input  logic                           BREADY,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            reg_wr_stb
);

  localparam int IW  = $clog2(NUM_REGS);
  localparam int LSB = addr_lsb(DATA_WIDTH);
  localparam logic [IW:0] NREGS = NUM_REGS[IW:0];

  logic                  wr_commit;
  logic [IW-1:0]         wr_idx;
  logic [DATA_WIDTH-1:0] wr_data;

  axi_lite_slave_wr_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .IDX_W      (IW)
  ) u_wr (
    .clk         (ACLK),
    .rst_n       (ARESETN),
    .awaddr      (AWADDR),
    .awvalid     (AWVALID),
    .awready     (AWREADY),
    .wdata       (WDATA),
    .wvalid      (WVALID),
    .wready      (WREADY),
    .bresp       (BRESP),
    .bvalid      (BVALID),
    .bready      (BREADY),
    .commit      (wr_commit),
    .commit_idx  (wr_idx),
    .commit_data (wr_data)
  );

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   stb_q, stb_d;

  rd_state_t             rd_state_q, rd_state_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  axi_resp_t             rresp_q, rresp_d;

  logic                  ar_hs, rd_ok;
  logic [IW-1:0]         ridx;

  // Apply a committed write and raise its one-cycle strobe.
  always_comb begin
    regs_d = regs_q;
    stb_d  = '0;
    if (wr_commit) begin
      regs_d[wr_idx] = wr_data;
      stb_d[wr_idx]  = 1'b1;
    end
  end

  // Read FSM: sample the pre-write register value at the AR edge.
  always_comb begin
    ar_hs = ARVALID & arready_q;
    ridx  = ARADDR[LSB +: IW];
    rd_ok = ((ARADDR >> (LSB + IW)) == '0)
          && ({1'b0, ridx} < NREGS);

    rd_state_d = rd_state_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;

    unique case (rd_state_q)
      RD_IDLE: begin
        if (ar_hs) begin
          rd_state_d = RD_DATA;
          arready_d  = 1'b0;
          rvalid_d   = 1'b1;
          rdata_d    = rd_ok ? regs_q[ridx] : '0;
          rresp_d    = rd_ok ? OKAY : SLVERR;
        end else begin
          arready_d  = 1'b1;
        end
      end
      RD_DATA: begin
        if (RREADY) begin
          rd_state_d = RD_IDLE;
          rvalid_d   = 1'b0;
          arready_d  = 1'b1;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  // Register array, strobes and read channel flops.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      stb_q      <= '0;
      rd_state_q <= RD_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= OKAY;
    end else begin
      regs_q     <= regs_d;
      stb_q      <= stb_d;
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

  assign reg_wr_stb = stb_q;
  assign ARREADY    = arready_q;
  assign RVALID     = rvalid_q;
  assign RDATA      = rdata_q;
  assign RRESP      = rresp_q;

endmodule
